// File: rtl/uart_rx_pkg.sv
// Shared constants, enums and helpers for the UART receive buffer controller.
package uart_rx_pkg;

  localparam int RX_DEPTH    = 32;
  localparam int RX_AW       = 5;
  localparam int RX_TO_CHARS = 4;

  typedef enum logic [1:0] {
    TRIG_1  = 2'b00,
    TRIG_8  = 2'b01,
    TRIG_16 = 2'b10,
    TRIG_28 = 2'b11
  } trig_lvl_e;

  typedef enum logic [1:0] {
    TO_IDLE  = 2'b00,
    TO_COUNT = 2'b01,
    TO_FIRE  = 2'b10
  } to_state_e;

  function automatic int unsigned trig_threshold(input trig_lvl_e lvl);
    int unsigned thr;
    case (lvl)
      TRIG_1:  thr = 1;
      TRIG_8:  thr = 8;
      TRIG_16: thr = 16;
      default: thr = 28;
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_ctrl_timer.sv
// Character-timeout detector: fires after TO_CHARS idle character times while data is pending.
module rx_timeout_timer
  import uart_rx_pkg::*;
#(
  parameter int TO_CHARS = RX_TO_CHARS
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic activity,
  input  logic nonempty,
  input  logic char_tick,
  input  logic flush,
  output logic timeout_irq
);

  localparam logic [2:0] LAST_TICK = 3'(TO_CHARS - 1);

  to_state_e  state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= TO_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (flush || !nonempty) begin
      state_next = TO_IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        TO_IDLE: begin
          state_next = TO_COUNT;
          cnt_next   = '0;
        end
        TO_COUNT: begin
          // Activity restarts the idle window even if a tick lands in the same cycle.
          if (activity) begin
            cnt_next = '0;
          end else if (char_tick) begin
            if (cnt_reg == LAST_TICK) begin
              state_next = TO_FIRE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + 3'd1;
            end
          end
        end
        TO_FIRE: begin
          if (activity) begin
            state_next = TO_COUNT;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = TO_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign timeout_irq = (state_reg == TO_FIRE);

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// Pointer/occupancy sequencing for the UART RX buffer RAM, with overrun and RX interrupts.
module uart_rx_fifo_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DEPTH    = RX_DEPTH,
  parameter int AW       = RX_AW,
  parameter int TO_CHARS = RX_TO_CHARS
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          rx_en_i,
  input  logic          fifo_en_i,
  input  logic          frame_valid_i,
  input  logic          rd_req_i,
  input  logic          flush_i,
  input  logic          clr_ovr_i,
  input  logic [1:0]    trig_lvl_i,
  input  logic          char_tick_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          rd_valid_o,
  output logic [AW:0]   count_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          overrun_o,
  output logic          rx_irq_o,
  output logic          timeout_irq_o
);

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          fifo_en_reg;
  logic          rd_valid_reg;
  logic          overrun_reg;
  logic          rx_irq_reg;

  logic          clear;
  logic          push_req;
  logic          push_acc;
  logic          pop_acc;
  logic          ovr_set;
  logic [AW:0]   capacity;
  logic [AW:0]   thresh;

  // A change of buffering mode invalidates everything stored, so treat it as a flush.
  assign clear    = flush_i | (fifo_en_i != fifo_en_reg);
  assign capacity = fifo_en_i ? (AW+1)'(DEPTH) : (AW+1)'(1);
  assign empty_o  = (count_reg == '0);
  assign full_o   = (count_reg == capacity);

  assign push_req = frame_valid_i & rx_en_i;
  assign pop_acc  = rd_req_i & !empty_o & !clear;
  assign push_acc = push_req & (!full_o | pop_acc) & !clear;
  assign ovr_set  = push_req & !push_acc & !clear;

  assign thresh = fifo_en_i ? (AW+1)'(trig_threshold(trig_lvl_e'(trig_lvl_i))) : (AW+1)'(1);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (clear) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_acc) wr_ptr_next = fifo_en_i ? wr_ptr_reg + 1'b1 : '0;
      if (pop_acc)  rd_ptr_next = fifo_en_i ? rd_ptr_reg + 1'b1 : '0;
      if (push_acc && !pop_acc) count_next = count_reg + 1'b1;
      if (pop_acc && !push_acc) count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      fifo_en_reg  <= 1'b1;
      rd_valid_reg <= 1'b0;
      overrun_reg  <= 1'b0;
      rx_irq_reg   <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      fifo_en_reg  <= fifo_en_i;
      rd_valid_reg <= pop_acc;
      rx_irq_reg   <= (count_next >= thresh);
      if (ovr_set)        overrun_reg <= 1'b1;
      else if (clr_ovr_i) overrun_reg <= 1'b0;
    end
  end

  rx_timeout_timer #(
    .TO_CHARS(TO_CHARS)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .activity   (push_acc | pop_acc),
    .nonempty   (count_next != '0),
    .char_tick  (char_tick_i),
    .flush      (clear),
    .timeout_irq(timeout_irq_o)
  );

  assign wr_en_o    = push_acc;
  assign wr_addr_o  = wr_ptr_reg;
  assign rd_addr_o  = rd_ptr_reg;
  assign rd_valid_o = rd_valid_reg;
  assign count_o    = count_reg;
  assign overrun_o  = overrun_reg;
  assign rx_irq_o   = rx_irq_reg;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Scoreboard bench: a queue-based buffer model predicts writes, read data and status flags.
module tb_uart_rx_fifo_ctrl;

  localparam int DEPTH    = 32;
  localparam int AW       = 5;
  localparam int TO_CHARS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_en, fifo_en, frame_valid, rd_req, flush, clr_ovr, char_tick;
  logic [1:0]    trig_lvl;
  logic          wr_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          empty, full, overrun, rx_irq, timeout_irq;

  uart_rx_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .TO_CHARS(TO_CHARS)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rx_en_i      (rx_en),
    .fifo_en_i    (fifo_en),
    .frame_valid_i(frame_valid),
    .rd_req_i     (rd_req),
    .flush_i      (flush),
    .clr_ovr_i    (clr_ovr),
    .trig_lvl_i   (trig_lvl),
    .char_tick_i  (char_tick),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .rd_addr_o    (rd_addr),
    .rd_valid_o   (rd_valid),
    .count_o      (count),
    .empty_o      (empty),
    .full_o       (full),
    .overrun_o    (overrun),
    .rx_irq_o     (rx_irq),
    .timeout_irq_o(timeout_irq)
  );

  always #5 clk = ~clk;

  // Buffer RAM addressed by the DUT, with registered read.
  logic [11:0] wdata, rd_data;
  logic [11:0] mem [DEPTH];
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wdata;
    rd_data <= mem[rd_addr];
  end

  int checks = 0;
  int errors = 0;

  // Reference model state: stored frames in arrival order plus running pointers.
  logic [11:0] m_q[$];
  logic [11:0] exp_rd[$];
  int          exp_wr[$];
  int          m_wr, m_rd, m_idle;
  logic        m_ovr, m_irq, m_fe_prev;
  logic        fe, rxen;
  logic [1:0]  trig;
  int          lvl_tab [4] = '{1, 8, 16, 28};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete(); exp_rd.delete(); exp_wr.delete();
    m_wr = 0; m_rd = 0; m_idle = 0;
    m_ovr = 1'b0; m_irq = 1'b0; m_fe_prev = 1'b1;
  endtask

  task automatic check_state();
    int cap;
    cap = fe ? DEPTH : 1;
    chk("count",       int'(count),       m_q.size());
    chk("empty",       int'(empty),       int'(m_q.size() == 0));
    chk("full",        int'(full),        int'(m_q.size() == cap));
    chk("overrun",     int'(overrun),     int'(m_ovr));
    chk("rx_irq",      int'(rx_irq),      int'(m_irq));
    chk("timeout_irq", int'(timeout_irq), int'(m_idle >= TO_CHARS));
    chk("wr_addr",     int'(wr_addr),     m_wr);
    chk("rd_addr",     int'(rd_addr),     m_rd);
  endtask

  // One clock of stimulus; called at posedge+2, returns at the next posedge+2.
  task automatic cyc(input logic fv, input logic rd, input logic fl, input logic co, input logic tk);
    logic        clear, push_req, push_acc, pop_acc;
    logic [11:0] d;
    int          cap, old_sz;
    d = 12'($urandom);
    frame_valid = fv; rd_req = rd; flush = fl; clr_ovr = co; char_tick = tk;
    fifo_en = fe; rx_en = rxen; trig_lvl = trig; wdata = d;

    cap      = fe ? DEPTH : 1;
    old_sz   = m_q.size();
    clear    = fl | (fe != m_fe_prev);
    push_req = fv & rxen;
    pop_acc  = rd & (old_sz > 0) & !clear;
    push_acc = push_req & ((old_sz < cap) | pop_acc) & !clear;
    if (clear) begin
      m_q.delete(); m_wr = 0; m_rd = 0;
    end else begin
      if (pop_acc) begin
        exp_rd.push_back(m_q.pop_front());
        m_rd = fe ? (m_rd + 1) % DEPTH : 0;
      end
      if (push_acc) begin
        m_q.push_back(d);
        exp_wr.push_back(m_wr);
        m_wr = fe ? (m_wr + 1) % DEPTH : 0;
      end
    end
    if (push_req && !push_acc && !clear) m_ovr = 1'b1;
    else if (co) m_ovr = 1'b0;
    m_irq = m_q.size() >= (fe ? lvl_tab[trig] : 1);
    if (clear || m_q.size() == 0 || push_acc || pop_acc || old_sz == 0) m_idle = 0;
    else if (tk && m_idle < TO_CHARS) m_idle++;
    m_fe_prev = fe;

    @(posedge clk); #2;
    check_state();
  endtask

  // Monitor: every write strobe and every read-valid is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL wr_en: got unexpected write at addr %0d, required none", wr_addr);
        end else begin
          int a;
          a = exp_wr.pop_front();
          if (int'(wr_addr) != a) begin
            errors++;
            $display("FAIL wr_addr_strobe: got %0d expected %0d", wr_addr, a);
          end
        end
      end
      if (exp_wr.size() != 0) begin
        checks++; errors++;
        $display("FAIL wr_en: got 0 expected 1 (addr %0d)", exp_wr[0]);
        exp_wr.delete();
      end
      if (rd_valid) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL rd_valid: got 1 expected 0");
        end else begin
          logic [11:0] e;
          e = exp_rd.pop_front();
          if (rd_data !== e) begin
            errors++;
            $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
          end
        end
      end
      if (exp_rd.size() > 1) begin
        checks++; errors++;
        $display("FAIL rd_valid: got 0 expected 1");
        void'(exp_rd.pop_front());
      end
    end
  end

  task automatic reset_checks();
    chk("rst_count",    int'(count),       0);
    chk("rst_empty",    int'(empty),       1);
    chk("rst_full",     int'(full),        0);
    chk("rst_overrun",  int'(overrun),     0);
    chk("rst_rx_irq",   int'(rx_irq),      0);
    chk("rst_timeout",  int'(timeout_irq), 0);
    chk("rst_rd_valid", int'(rd_valid),    0);
    chk("rst_wr_en",    int'(wr_en),       0);
    chk("rst_wr_addr",  int'(wr_addr),     0);
    chk("rst_rd_addr",  int'(rd_addr),     0);
  endtask

  task automatic idle_inputs();
    frame_valid = 0; rd_req = 0; flush = 0; clr_ovr = 0; char_tick = 0;
  endtask

  initial begin
    fe = 1'b1; rxen = 1'b1; trig = 2'b01;
    fifo_en = 1'b1; rx_en = 1'b1; trig_lvl = 2'b01; wdata = '0;
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #1 reset_checks();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Three pushes at trigger level 8, then level 1.
    repeat (3) cyc(1, 0, 0, 0, 0);
    trig = 2'b00;
    cyc(0, 0, 0, 0, 0);

    // Fill to 32 entries, then an overrunning 33rd push, then clear overrun.
    cyc(0, 0, 1, 0, 0);
    repeat (32) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);

    // Walk both pointers to 31, refill, then push+pop while full wraps both to 0.
    cyc(0, 0, 1, 0, 0);
    repeat (31) cyc(1, 0, 0, 0, 0);
    repeat (31) cyc(0, 1, 0, 0, 0);
    repeat (32) cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Push into empty with a simultaneous read request.
    cyc(0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Character timeout after four idle ticks, cleared by the pop that empties.
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (4) begin
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
    end
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Ten pushes then flush; holding mode overrun survives a flush.
    repeat (10) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    fe = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    fe = 1'b1;
    cyc(0, 0, 0, 1, 0);

    // Randomised traffic with push-heavy and pop-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      logic push_heavy;
      push_heavy = ((i / 150) % 2) == 0;
      if ($urandom_range(0, 99) < 1) fe = ~fe;
      if ($urandom_range(0, 99) < 5) trig = 2'($urandom);
      rxen = ($urandom_range(0, 99) >= 5);
      cyc(($urandom_range(0, 99) < (push_heavy ? 70 : 30)),
          ($urandom_range(0, 99) < (push_heavy ? 25 : 60)),
          ($urandom_range(0, 199) == 0),
          ($urandom_range(0, 99) < 3),
          ($urandom_range(0, 99) < 25));
      // Occasional asynchronous reset in the middle of traffic.
      if (i == 1700) begin
        #3;
        idle_inputs();
        rst_n = 1'b0;
        fe = 1'b1; fifo_en = 1'b1;
        model_reset();
        #1 reset_checks();
        @(posedge clk); #2 rst_n = 1'b1;
      end
    end

    fe = 1'b1; rxen = 1'b1;
    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("scoreboard_rd_drained", exp_rd.size(), 0);
    chk("scoreboard_wr_drained", exp_wr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
